wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single W-bit register-file write-back port between two producers:
//  requester A (ALU result) and requester B (load data). Round-robin arbitration
//  over valid/ready handshakes; drives the select of the 2:1 write-back data mux
//  (sel=0 -> A, sel=1 -> B) and registers the winning write for the register file.
//  Sits between execute/memory stages and the register-file write port.
// PARAMETERS
//  W   32  data width of each requester and of the write port
//  AW  5   register address width (32 registers; address 0 is hardwired zero)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  stall      in   1   write-back stall; when 1 no request is granted
//  a_valid    in   1   requester A holds a write
//  a_addr     in   AW  requester A destination register
//  a_data     in   W   requester A write data
//  a_ready    out  1   A's write accepted this cycle (combinational grant)
//  b_valid    in   1   requester B holds a write
//  b_addr     in   AW  requester B destination register
//  b_data     in   W   requester B write data
//  b_ready    out  1   B's write accepted this cycle (combinational grant)
//  mux_sel    out  1   select for the write-back data mux; 0=A, 1=B (combinational)
//  rf_we      out  1   registered register-file write enable
//  rf_waddr   out  AW  registered register-file write address
//  rf_wdata   out  W   registered register-file write data
// BEHAVIOUR
//  - State: one flop last_b (1 = B granted most recently). Reset value 1, so A
//    wins the first contention after reset.
//  - Grant (combinational, same cycle): stall=1 -> no grant. Only A valid -> A.
//    Only B valid -> B. Both valid -> last_b=1 ? A : B. Neither -> no grant.
//  - a_ready / b_ready = grant to that requester; at most one high per cycle.
//    Transfer occurs on a cycle where valid & ready; requester holds addr/data
//    stable while valid & !ready. Grant never depends on ready of the sink.
//  - mux_sel = 1 when B granted, 0 when A granted, holds previous value when
//    no grant (registered copy, reset 0) to avoid glitching the datapath select.
//  - last_b updates on every transfer to the granted side; unchanged otherwise.
//  - Write register: latency 1. On a transfer, next cycle rf_we=1,
//    rf_waddr/rf_wdata = granted addr/data; otherwise rf_we=0 next cycle and
//    rf_waddr/rf_wdata hold their last value.
//  - Register 0: a transfer with addr==0 is accepted (ready=1, last_b updates)
//    but produces rf_we=0 next cycle.
//  - Back-to-back: one transfer per cycle sustained; both valid continuously
//    gives strict alternation A,B,A,B...
//  - stall asserted while both valid: no grant, last_b and mux_sel hold; on
//    deassert arbitration resumes from the held last_b.
//  - Reset mid-operation (async assert): rf_we=0, rf_waddr=0, rf_wdata=0,
//    mux_sel=0, last_b=1 immediately; readies drop as grant logic sees the
//    reset state only via stall/valid (readies forced 0 while rst_n=0).
// TESTING
//  1 Reset: rst_n=0 with a_valid=b_valid=1 -> a_ready=b_ready=0, rf_we=0,
//    rf_wdata=0, mux_sel=0; release -> first cycle grants A.
//  2 Single A: a_valid=1,a_addr=5,a_data=0xDEADBEEF -> a_ready=1 same cycle,
//    mux_sel=0; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
//  3 Contention: both valid for 4 cycles (A addr 1, B addr 2) -> grants
//    A,B,A,B; rf_waddr sequence 1,2,1,2 one cycle later; mux_sel 0,1,0,1.
//  4 Stall: both valid, stall=1 for 3 cycles after a B grant -> no ready,
//    rf_we=0, mux_sel stays 1; stall=0 -> A granted first.
//  5 Zero reg: b_valid=1,b_addr=0,b_data=0x12345678 -> b_ready=1, next cycle
//    rf_we=0; following contention grants A (last_b=1).
//  6 Async reset mid-stream during alternation -> outputs clear within the
//    reset assertion, no rf_we pulse; after release A wins first.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write-back port between two producers:
// requester A (ALU result) and requester B (load data). The arbiter grants at
// most one requester per cycle using valid/ready handshakes. It round-robins
// between the two under contention. It drives the select of the 2:1 write-back
// data mux and registers the winning write for the register file.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   stall               write-back stall; while high nothing is granted
//   a_valid/addr/data   requester A write request (ALU)
//   a_ready             A accepted this cycle (combinational grant)
//   b_valid/addr/data   requester B write request (load)
//   b_ready             B accepted this cycle (combinational grant)
//   mux_sel             write-back data mux select, 0=A, 1=B (combinational,
//                       holds its last value when nothing is granted)
//   rf_we/waddr/wdata   registered register-file write, one cycle after the
//                       transfer; writes to register 0 are dropped
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [W-1:0]  a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [W-1:0]  b_data,
  output logic          b_ready,
  output logic          mux_sel,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [W-1:0]  rf_wdata
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_A    = 2'b01,
    GNT_B    = 2'b10
  } grant_e;

  // Round-robin pointer: 1 means B won the most recent transfer, so A gets
  // priority on the next contention. It resets to 1, which lets A win first.
  logic          last_b_q,   last_b_d;
  // Registered copy of the mux select. It keeps the datapath select steady
  // through idle cycles instead of snapping back to a default.
  logic          mux_sel_q,  mux_sel_d;
  logic          rf_we_q,    rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [W-1:0]  rf_wdata_q, rf_wdata_d;

  grant_e        grant;
  logic [AW-1:0] win_addr;
  logic [W-1:0]  win_data;

  // Grant decision. It looks only at stall, the valids and the round-robin
  // pointer. It never depends on downstream readiness, because the register
  // file write port always accepts. Readies are held low during reset, so
  // nothing can be accepted while the state is being cleared.
  // NOTE: every signal assigned in an always_comb gets a default on the first
  // line. A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    grant = GNT_NONE;
    if (rst_n && !stall) begin
      unique case ({a_valid, b_valid})
        2'b10:   grant = GNT_A;
        2'b01:   grant = GNT_B;
        2'b11:   grant = last_b_q ? GNT_A : GNT_B;
        default: grant = GNT_NONE;
      endcase
    end
  end

  assign a_ready = (grant == GNT_A);
  assign b_ready = (grant == GNT_B);

  // Winning request. A grant implies the matching valid, so every granted
  // cycle is a transfer.
  always_comb begin
    win_addr = a_addr;
    win_data = a_data;
    if (grant == GNT_B) begin
      win_addr = b_addr;
      win_data = b_data;
    end
  end

  // Next-state logic for the pointer, the select and the write register.
  always_comb begin
    last_b_d   = last_b_q;
    mux_sel_d  = mux_sel_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    if (grant != GNT_NONE) begin
      last_b_d  = (grant == GNT_B);
      mux_sel_d = (grant == GNT_B);
      // Register 0 is hardwired to zero. The handshake still completes and
      // the pointer still advances, but no write reaches the register file.
      // The address and data registers keep the last real write.
      if (win_addr != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = win_addr;
        rf_wdata_d = win_data;
      end
    end
  end

  // The select follows the grant in the same cycle and falls back to the
  // registered value when idle. Reset clears mux_sel_q and blocks any grant,
  // so mux_sel reads 0 during reset.
  assign mux_sel = (grant == GNT_NONE) ? mux_sel_q : (grant == GNT_B);

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values no matter what order the statements run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q   <= 1'b1;
      mux_sel_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      last_b_q   <= last_b_d;
      mux_sel_q  <= mux_sel_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Bench for wb_port_arbiter. A table of per-cycle vectors holds the inputs and
// the expected handshake outputs (a_ready, b_ready, mux_sel). These are
// hand-derived from the round-robin rules. Each applied vector also pushes the
// register-file write it should produce onto a scoreboard queue. That entry is
// popped and compared one clock later. The reset cases are hand-written.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr,  b_addr;
  logic [W-1:0]  a_data,  b_data;
  logic          a_ready, b_ready, mux_sel;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [W-1:0]  rf_wdata;

  always #5 clk = ~clk;

  wb_port_arbiter #(.W(W), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .mux_sel  (mux_sel),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  typedef struct {
    logic          stall;
    logic          av;
    logic [AW-1:0] aaddr;
    logic [W-1:0]  adata;
    logic          bv;
    logic [AW-1:0] baddr;
    logic [W-1:0]  bdata;
    logic          ea;
    logic          eb;
    logic          esel;
  } vec_t;

  typedef struct {
    logic          we;
    logic          chk_data;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  // Last value the write register is expected to hold, and whether that value
  // is known (it is not, right after a register-0 transfer).
  logic [AW-1:0] m_addr  = '0;
  logic [W-1:0]  m_data  = '0;
  logic          m_known = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic st,
                              input logic av, input logic [AW-1:0] aa, input logic [W-1:0] ad,
                              input logic bv, input logic [AW-1:0] ba, input logic [W-1:0] bd,
                              input logic ea, input logic eb, input logic es);
    vec_t v;
    v.stall = st; v.av = av; v.aaddr = aa; v.adata = ad;
    v.bv = bv; v.baddr = ba; v.bdata = bd;
    v.ea = ea; v.eb = eb; v.esel = es;
    return v;
  endfunction

  // One cycle: drive just after a rising edge, check the combinational outputs
  // on the falling edge, push the expected write, then pop and compare it
  // just after the next rising edge.
  task automatic step(input vec_t v, input string tag);
    exp_t          e;
    logic          xfer;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    stall   = v.stall;
    a_valid = v.av; a_addr = v.aaddr; a_data = v.adata;
    b_valid = v.bv; b_addr = v.baddr; b_data = v.bdata;
    @(negedge clk);
    check({tag, " a_ready"}, 32'(a_ready), 32'(v.ea));
    check({tag, " b_ready"}, 32'(b_ready), 32'(v.eb));
    check({tag, " mux_sel"}, 32'(mux_sel), 32'(v.esel));

    xfer = v.ea | v.eb;
    wa   = v.ea ? v.aaddr : v.baddr;
    wd   = v.ea ? v.adata : v.bdata;
    if (xfer && wa != '0) begin
      m_addr = wa; m_data = wd; m_known = 1'b1;
      e.we = 1'b1; e.chk_data = 1'b1;
    end else begin
      if (xfer) m_known = 1'b0;
      e.we = 1'b0; e.chk_data = m_known;
    end
    e.addr = m_addr; e.data = m_data;
    sb.push_back(e);

    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " rf_we"}, 32'(rf_we), 32'(e.we));
      if (e.chk_data) begin
        check({tag, " rf_waddr"}, 32'(rf_waddr), 32'(e.addr));
        check({tag, " rf_wdata"}, rf_wdata, e.data);
      end
    end
  endtask

  localparam logic [W-1:0] DA = 32'h1111_1111;
  localparam logic [W-1:0] DB = 32'h2222_2222;
  localparam logic [W-1:0] D3 = 32'h3333_3333;
  localparam logic [W-1:0] D4 = 32'h4444_4444;

  vec_t vecs[18];

  initial begin
    //           st  av aa  ad            bv ba  bd            ea eb sel
    vecs[0]  = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 0); // idle after reset
    vecs[1]  = mk(0, 1, 1, DA,           1, 2, DB,           1, 0, 0); // contention: A
    vecs[2]  = mk(0, 1, 1, DA,           1, 2, DB,           0, 1, 1); // B
    vecs[3]  = mk(0, 1, 1, DA,           1, 2, DB,           1, 0, 0); // A
    vecs[4]  = mk(0, 1, 1, DA,           1, 2, DB,           0, 1, 1); // B
    vecs[5]  = mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 1); // idle: sel holds 1
    vecs[6]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 0, 0); // single A
    vecs[7]  = mk(0, 0, 0, 0,            1, 7, 32'hCAFEF00D, 0, 1, 1); // single B
    vecs[8]  = mk(1, 1, 3, D3,           1, 4, D4,           0, 0, 1); // stall x3
    vecs[9]  = mk(1, 1, 3, D3,           1, 4, D4,           0, 0, 1);
    vecs[10] = mk(1, 1, 3, D3,           1, 4, D4,           0, 0, 1);
    vecs[11] = mk(0, 1, 3, D3,           1, 4, D4,           1, 0, 0); // resume: A first
    vecs[12] = mk(0, 1, 3, D3,           1, 4, D4,           0, 1, 1); // B
    vecs[13] = mk(0, 0, 0, 0,            1, 0, 32'h12345678, 0, 1, 1); // B to reg 0
    vecs[14] = mk(0, 1, 3, D3,           1, 4, D4,           1, 0, 0); // A wins (last_b=1)
    vecs[15] = mk(1, 1, 3, D3,           0, 0, 0,            0, 0, 0); // stall, A only
    vecs[16] = mk(0, 1, 0, 32'hAAAA0000, 0, 0, 0,            1, 0, 0); // A to reg 0
    vecs[17] = mk(0, 1, 1, DA,           1, 2, DB,           0, 1, 1); // B wins (last_b=0)

    // Reset with both requesters valid: nothing granted, outputs cleared.
    rst_n = 1'b0; stall = 1'b0;
    a_valid = 1'b1; a_addr = 5'd1; a_data = DA;
    b_valid = 1'b1; b_addr = 5'd2; b_data = DB;
    #2;
    check("rst a_ready",  32'(a_ready),  32'd0);
    check("rst b_ready",  32'(b_ready),  32'd0);
    check("rst rf_we",    32'(rf_we),    32'd0);
    check("rst rf_wdata", rf_wdata,      32'd0);
    check("rst mux_sel",  32'(mux_sel),  32'd0);
    @(posedge clk); #1;
    check("rst hold rf_we", 32'(rf_we), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Async reset during alternation. Pointer is 1 after vec17, so A goes next.
    step(mk(0, 1, 1, DA, 1, 2, DB, 1, 0, 0), "pre-rst A");
    step(mk(0, 1, 1, DA, 1, 2, DB, 0, 1, 1), "pre-rst B");
    #3 rst_n = 1'b0;  // mid-cycle, rf_we is high from the B write
    #1;
    check("mid-rst rf_we",    32'(rf_we),    32'd0);
    check("mid-rst rf_waddr", 32'(rf_waddr), 32'd0);
    check("mid-rst rf_wdata", rf_wdata,      32'd0);
    check("mid-rst mux_sel",  32'(mux_sel),  32'd0);
    check("mid-rst a_ready",  32'(a_ready),  32'd0);
    check("mid-rst b_ready",  32'(b_ready),  32'd0);
    @(posedge clk); #1;
    check("mid-rst no we pulse", 32'(rf_we), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    m_addr = '0; m_data = '0; m_known = 1'b1;
    step(mk(0, 1, 1, DA, 1, 2, DB, 1, 0, 0), "post-rst A");
    step(mk(0, 1, 1, DA, 1, 2, DB, 0, 1, 1), "post-rst B");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
